// File: rtl/pll_lock_rst_ctrl.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock, then releases the
// downstream system reset. Retries the PLL on lock timeout and keeps debug counters.
module pll_lock_rst_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  clr_cnt,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  locked,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [3:0]            timeout_cnt,
  output logic                  err
);

  localparam int MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [1:0]              sync_reg;
  logic                    lock_s;
  logic                    pll_rst_reg, pll_rst_next;
  logic                    sys_rst_n_reg, sys_rst_n_next;
  logic                    locked_reg, locked_next;
  logic [LOSS_CNT_W-1:0]   loss_cnt_reg, loss_cnt_next;
  logic [3:0]              timeout_cnt_reg, timeout_cnt_next;
  logic                    err_reg, err_next;
  logic                    loss_ev, timeout_ev;

  // pll_lock is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], pll_lock};
  end

  assign lock_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_PLL_RST;
      cnt_reg         <= '0;
      pll_rst_reg     <= 1'b1;
      sys_rst_n_reg   <= 1'b0;
      locked_reg      <= 1'b0;
      loss_cnt_reg    <= '0;
      timeout_cnt_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      pll_rst_reg     <= pll_rst_next;
      sys_rst_n_reg   <= sys_rst_n_next;
      locked_reg      <= locked_next;
      loss_cnt_reg    <= loss_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_ev    = 1'b0;
    timeout_ev = 1'b0;
    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == PR_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          state_next = ST_PLL_RST;
          cnt_next   = '0;
          timeout_ev = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // a dropout here is treated as a glitch: restart the wait, no error
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == ST_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
          loss_ev    = 1'b1;
        end
      end
      default: begin
        state_next = ST_PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM
  always_comb begin
    pll_rst_next   = (state_next == ST_PLL_RST);
    sys_rst_n_next = (state_next == ST_RUN);
    locked_next    = (state_next == ST_RUN);

    loss_cnt_next = loss_cnt_reg;
    if (loss_ev)
      loss_cnt_next = clr_cnt ? LOSS_CNT_W'(1)
                    : (&loss_cnt_reg ? loss_cnt_reg : loss_cnt_reg + LOSS_CNT_W'(1));
    else if (clr_cnt)
      loss_cnt_next = '0;

    timeout_cnt_next = timeout_cnt_reg;
    if (timeout_ev)
      timeout_cnt_next = clr_cnt ? 4'd1
                       : (&timeout_cnt_reg ? timeout_cnt_reg : timeout_cnt_reg + 4'd1);
    else if (clr_cnt)
      timeout_cnt_next = 4'd0;

    err_next = err_reg;
    if (loss_ev || timeout_ev) err_next = 1'b1;
    else if (clr_cnt)          err_next = 1'b0;
  end

  assign pll_rst     = pll_rst_reg;
  assign sys_rst_n   = sys_rst_n_reg;
  assign locked      = locked_reg;
  assign loss_cnt    = loss_cnt_reg;
  assign timeout_cnt = timeout_cnt_reg;
  assign err         = err_reg;

endmodule
